// File: rtl/gun_pkg.sv
// Shared types and defaults for the light-gun front end.
package gun_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_FRAME,
      BLACK,
      TARGET,
      RESULT,
      COOLDOWN
   } gun_state_e;

   localparam int DEF_DEBOUNCE_CYCLES = 650_000;  // 10 ms at 65 MHz
   localparam int DEF_PD_MIN_CYCLES   = 64;
   localparam int DEF_TARGET_FRAMES   = 1;
   localparam int DEF_COOLDOWN_FRAMES = 15;

   // Bits needed to hold values 0..max_val.
   function automatic int cnt_w(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/gun_debounce.sv
// Raw-pin conditioning: 2-FF synchronizer, polarity normalisation and
// a restart-on-bounce debouncer that reports inactive-to-active presses.
module gun_sync #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);
   logic s1_q, s2_q;

   // Two flops in series to resolve metastability on the async pin.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_q <= RST_VAL;
         s2_q <= RST_VAL;
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
      end
   end

   assign q_o = s2_q;
endmodule

module gun_debounce
   import gun_pkg::*;
#(
   parameter int CYCLES     = DEF_DEBOUNCE_CYCLES,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic raw_i,
   output logic press_o
);
   localparam int CW = cnt_w(CYCLES);

   logic          sync_raw, sync_act;
   logic          level_q, level_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Sync flops come out of reset at the pin's idle level.
   gun_sync #(.RST_VAL(ACTIVE_LOW)) u_sync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (raw_i),
      .q_o   (sync_raw)
   );

   assign sync_act = sync_raw ^ ACTIVE_LOW;

   // Count consecutive cycles of disagreement; flip the level after CYCLES of them.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync_act != level_q) begin
         if (cnt_q == CW'(CYCLES - 1)) level_d = sync_act;
         else                          cnt_d   = cnt_q + 1'b1;
      end
   end

   // Level resets to active so a trigger held through reset never looks like a press.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         level_q <= 1'b1;
         cnt_q   <= '0;
      end else begin
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   assign press_o = level_d & ~level_q;
endmodule

// File: rtl/gun_controller.sv
// Light-gun front end: trigger/photodetector conditioning and the
// black-frame / target-frame flash sequence, one hit or miss per shot.
module gun_controller
   import gun_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int PD_MIN_CYCLES   = DEF_PD_MIN_CYCLES,
   parameter int TARGET_FRAMES   = DEF_TARGET_FRAMES,
   parameter int COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES,
   parameter int TRIG_ACTIVE_LOW = 1,
   parameter int PD_ACTIVE_LOW   = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic gun_trigger,
   input  logic gun_photodetector,
   input  logic frame_start,
   output logic flash_black,
   output logic flash_target,
   output logic shot_fired,
   output logic hit,
   output logic miss,
   output logic busy
);
   localparam int PW = cnt_w(PD_MIN_CYCLES);
   localparam int FW = cnt_w(TARGET_FRAMES);
   localparam int CW = cnt_w(COOLDOWN_FRAMES);
   localparam bit TRIG_AL = (TRIG_ACTIVE_LOW != 0);
   localparam bit PD_AL   = (PD_ACTIVE_LOW != 0);

   logic          press;
   logic          pd_sync, pd_act, light;
   logic [PW-1:0] pd_cnt_q, pd_cnt_d;

   gun_state_e    state_q, state_d;
   logic [FW-1:0] frame_cnt_q, frame_cnt_d;
   logic [CW-1:0] cool_cnt_q, cool_cnt_d;
   logic          cheat_q, cheat_d, seen_q, seen_d;
   logic          fb_d, ft_d, sf_d, hit_d, miss_d, busy_d;

   gun_debounce #(.CYCLES(DEBOUNCE_CYCLES), .ACTIVE_LOW(TRIG_AL)) u_trig (
      .clk_i   (clk),
      .rst_i   (rst),
      .raw_i   (gun_trigger),
      .press_o (press)
   );

   gun_sync #(.RST_VAL(PD_AL)) u_pd_sync (
      .clk_i (clk),
      .rst_i (rst),
      .d_i   (gun_photodetector),
      .q_o   (pd_sync)
   );

   assign pd_act = pd_sync ^ PD_AL;
   assign light  = (pd_cnt_q == PW'(PD_MIN_CYCLES));

   // Light filter: saturating run-length of active detector cycles.
   always_comb begin
      pd_cnt_d = '0;
      if (pd_act) pd_cnt_d = light ? pd_cnt_q : pd_cnt_q + 1'b1;
   end

   // Light filter register.
   always_ff @(posedge clk) begin
      if (rst) pd_cnt_q <= '0;
      else     pd_cnt_q <= pd_cnt_d;
   end

   // State, counters, flags and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         frame_cnt_q  <= '0;
         cool_cnt_q   <= '0;
         cheat_q      <= 1'b0;
         seen_q       <= 1'b0;
         flash_black  <= 1'b0;
         flash_target <= 1'b0;
         shot_fired   <= 1'b0;
         hit          <= 1'b0;
         miss         <= 1'b0;
         busy         <= 1'b0;
      end else begin
         state_q      <= state_d;
         frame_cnt_q  <= frame_cnt_d;
         cool_cnt_q   <= cool_cnt_d;
         cheat_q      <= cheat_d;
         seen_q       <= seen_d;
         flash_black  <= fb_d;
         flash_target <= ft_d;
         shot_fired   <= sf_d;
         hit          <= hit_d;
         miss         <= miss_d;
         busy         <= busy_d;
      end
   end

   // Next state; light on the BLACK->TARGET edge still lands in cheat.
   always_comb begin
      state_d     = state_q;
      frame_cnt_d = frame_cnt_q;
      cool_cnt_d  = cool_cnt_q;
      cheat_d     = cheat_q;
      seen_d      = seen_q;
      case (state_q)
         IDLE:       if (press) state_d = WAIT_FRAME;
         WAIT_FRAME: if (frame_start) state_d = BLACK;
         BLACK: begin
            if (light) cheat_d = 1'b1;
            if (frame_start) begin
               state_d     = TARGET;
               frame_cnt_d = '0;
            end
         end
         TARGET: begin
            if (light) seen_d = 1'b1;
            if (frame_start) begin
               if (frame_cnt_q == FW'(TARGET_FRAMES - 1)) state_d = RESULT;
               else frame_cnt_d = frame_cnt_q + 1'b1;
            end
         end
         RESULT: begin
            cheat_d    = 1'b0;
            seen_d     = 1'b0;
            cool_cnt_d = '0;
            state_d    = COOLDOWN;
         end
         COOLDOWN: begin
            if (frame_start) begin
               if (cool_cnt_q == CW'(COOLDOWN_FRAMES - 1)) state_d = IDLE;
               else cool_cnt_d = cool_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output next values; flashes follow the upcoming state so they align with it.
   always_comb begin
      fb_d   = (state_d == BLACK);
      ft_d   = (state_d == TARGET);
      sf_d   = (state_q == IDLE) && press;
      hit_d  = (state_q == RESULT) && seen_q && !cheat_q;
      miss_d = (state_q == RESULT) && !(seen_q && !cheat_q);
      busy_d = (state_d != IDLE);
   end

endmodule

// File: tb/tb_gun_controller.sv
// Directed bench for gun_controller with short debounce and 100-cycle frames.
module tb_gun_controller;
   logic clk = 1'b0;
   logic rst, trig, pd, frame_start;
   logic flash_black, flash_target, shot_fired, hit, miss, busy;
   logic frame_en, fs_auto, fs_man;
   int   fcnt = 0;

   int n_checks = 0, n_err = 0;
   int n_shot = 0, n_hit = 0, n_miss = 0, n_both = 0;
   int s0, h0, m0;

   gun_controller #(
      .DEBOUNCE_CYCLES (8),
      .PD_MIN_CYCLES   (4),
      .TARGET_FRAMES   (1),
      .COOLDOWN_FRAMES (2),
      .TRIG_ACTIVE_LOW (1),
      .PD_ACTIVE_LOW   (1)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .gun_trigger       (trig),
      .gun_photodetector (pd),
      .frame_start       (frame_start),
      .flash_black       (flash_black),
      .flash_target      (flash_target),
      .shot_fired        (shot_fired),
      .hit               (hit),
      .miss              (miss),
      .busy              (busy)
   );

   initial forever #5 clk = ~clk;

   assign frame_start = frame_en ? fs_auto : fs_man;

   // Free-running frame pulse every 100 cycles.
   initial begin
      fs_auto = 1'b0;
      forever begin
         @(negedge clk);
         fs_auto = (fcnt == 99);
         fcnt    = (fcnt == 99) ? 0 : fcnt + 1;
      end
   end

   // Pulse counters.
   initial forever begin
      @(negedge clk);
      if (shot_fired)  n_shot++;
      if (hit)         n_hit++;
      if (miss)        n_miss++;
      if (hit && miss) n_both++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic cond(input int sel);
      case (sel)
         0:       return flash_black;
         1:       return flash_target;
         3:       return (n_hit != h0) || (n_miss != m0);
         default: return !busy;
      endcase
   endfunction

   task automatic wait_for(input string tag, input int sel, input int lim);
      int n = 0;
      while (!cond(sel) && n < lim) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_reached"}, 32'(cond(sel)), 1);
   endtask

   task automatic pull(input int low_cyc, input int high_cyc);
      trig = 1'b0;
      repeat (low_cyc) @(negedge clk);
      trig = 1'b1;
      repeat (high_cyc) @(negedge clk);
   endtask

   task automatic snap();
      s0 = n_shot; h0 = n_hit; m0 = n_miss;
   endtask

   initial begin
      rst = 1'b1; trig = 1'b1; pd = 1'b1; frame_en = 1'b1; fs_man = 1'b0;
      s0 = 0; h0 = 0; m0 = 0;
      repeat (4) @(negedge clk);
      check("reset_outs", {26'd0, flash_black, flash_target, shot_fired, hit, miss, busy}, 0);
      rst = 1'b0;
      repeat (30) @(negedge clk);
      check("post_reset_no_shot", n_shot, 0);

      // Clean press, light only during the target frame -> hit.
      snap();
      pull(20, 20);
      check("t1_shot", n_shot - s0, 1);
      wait_for("t1_target", 1, 400);
      repeat (20) @(negedge clk);
      pd = 1'b0;
      repeat (10) @(negedge clk);
      pd = 1'b1;
      wait_for("t1_idle", 2, 600);
      check("t1_hit", n_hit - h0, 1);
      check("t1_miss", n_miss - m0, 0);

      // Aimed at a lamp: light through black and target -> miss.
      snap();
      pd = 1'b0;
      pull(20, 20);
      wait_for("t2_target", 1, 400);
      wait_for("t2_idle", 2, 600);
      pd = 1'b1;
      check("t2_shot", n_shot - s0, 1);
      check("t2_hit", n_hit - h0, 0);
      check("t2_miss", n_miss - m0, 1);

      // Bouncing trigger gives one shot; a press during cooldown is dropped.
      snap();
      for (int i = 0; i < 14; i++) begin
         trig = ~trig;
         repeat (3) @(negedge clk);
      end
      pull(20, 20);
      check("t3_one_shot", n_shot - s0, 1);
      wait_for("t3_result", 3, 600);
      pull(20, 20);
      wait_for("t3_idle", 2, 600);
      check("t3_no_second_shot", n_shot - s0, 1);
      check("t3_miss", n_miss - m0, 1);
      check("t3_hit", n_hit - h0, 0);

      // Short detector bursts never saturate the filter -> miss.
      snap();
      pull(20, 20);
      wait_for("t4_target", 1, 400);
      for (int i = 0; i < 5; i++) begin
         pd = 1'b0; repeat (3) @(negedge clk);
         pd = 1'b1; repeat (3) @(negedge clk);
      end
      wait_for("t4_idle", 2, 600);
      check("t4_hit", n_hit - h0, 0);
      check("t4_miss", n_miss - m0, 1);

      // Trigger held through reset never fires.
      snap();
      trig = 1'b0;
      rst  = 1'b1;
      repeat (5) @(negedge clk);
      rst = 1'b0;
      repeat (50) @(negedge clk);
      check("t5_held_no_shot", n_shot - s0, 0);
      check("t5_held_idle", busy, 0);
      trig = 1'b1;
      repeat (30) @(negedge clk);
      check("t5_release_no_shot", n_shot - s0, 0);

      // Reset in the middle of the target frame.
      snap();
      pull(20, 20);
      wait_for("t5_target", 1, 400);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("t5_mid_reset_outs", {26'd0, flash_black, flash_target, shot_fired, hit, miss, busy}, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (300) @(negedge clk);
      check("t5_mid_no_hit", n_hit - h0, 0);
      check("t5_mid_no_miss", n_miss - m0, 0);
      check("t5_mid_idle", busy, 0);

      // Press landing on the same cycle as frame_start: that frame is not the black one.
      frame_en = 1'b0;
      repeat (5) @(negedge clk);
      snap();
      trig = 1'b0;
      repeat (9) @(negedge clk);
      fs_man = 1'b1;
      @(negedge clk);
      fs_man = 1'b0;
      check("t6_shot_latency", shot_fired, 1);
      check("t6_black_not_yet", flash_black, 0);
      trig = 1'b1;
      repeat (20) @(negedge clk);
      check("t6_still_waiting", flash_black, 0);
      check("t6_busy", busy, 1);
      fs_man = 1'b1;
      @(negedge clk);
      fs_man = 1'b0;
      check("t6_black_rise", flash_black, 1);
      repeat (5) @(negedge clk);
      fs_man = 1'b1;
      @(negedge clk);
      fs_man = 1'b0;
      check("t6_black_fall", flash_black, 0);
      check("t6_target_rise", flash_target, 1);
      repeat (5) @(negedge clk);
      fs_man = 1'b1;
      @(negedge clk);
      fs_man = 1'b0;
      frame_en = 1'b1;
      wait_for("t6_idle", 2, 600);
      check("t6_shot_count", n_shot - s0, 1);
      check("t6_miss", n_miss - m0, 1);

      check("hit_miss_exclusive", n_both, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
